// File: rtl/gates_pkg.sv
// Shared types and word layout for the gates result serializer.
package gates_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NWORDS = 7;
  localparam int IDX_W  = 3;

  localparam logic [IDX_W-1:0] IDX_AND  = 3'd0;
  localparam logic [IDX_W-1:0] IDX_OR   = 3'd1;
  localparam logic [IDX_W-1:0] IDX_XOR  = 3'd2;
  localparam logic [IDX_W-1:0] IDX_NOR  = 3'd3;
  localparam logic [IDX_W-1:0] IDX_NAND = 3'd4;
  localparam logic [IDX_W-1:0] IDX_MUX  = 3'd5;
  localparam logic [IDX_W-1:0] IDX_BUS  = 3'd6;

endpackage

// File: rtl/gates_snap_reg.sv
// Capture bank for one frame of gate results; loads all words at once, reads one by index.
module gates_snap_reg
  import gates_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [NWORDS-1:0][WIDTH-1:0]  din,
  input  logic [IDX_W-1:0]              ridx,
  output logic [WIDTH-1:0]              dout
);

  logic [NWORDS-1:0][WIDTH-1:0] q;

  generate
    for (genvar i = 0; i < NWORDS; i++) begin : g_word
      always_ff @(posedge clk) begin
        if (reset)     q[i] <= '0;
        else if (load) q[i] <= din[i];
      end
    end
  endgenerate

  // Index 7 is never reached by the counter; return zero rather than alias.
  always_comb begin
    dout = '0;
    if (ridx < IDX_W'(NWORDS)) dout = q[ridx];
  end

endmodule

// File: rtl/gates_result_serializer.sv
// Snapshots the seven gate results on start and streams them as words over valid/ready.
module gates_result_serializer
  import gates_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] y1,
  input  logic [WIDTH-1:0] y2,
  input  logic [WIDTH-1:0] y3,
  input  logic [WIDTH-1:0] y4,
  input  logic [WIDTH-1:0] y5,
  input  logic [WIDTH-1:0] y6,
  input  logic [WIDTH-1:0] y7,
  input  logic             s,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_zflag,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  state_t                       state, state_n;
  logic [IDX_W-1:0]             idx, idx_n;
  logic                         zflag, zflag_n;
  logic                         load;
  logic [NWORDS-1:0][WIDTH-1:0] din;
  logic [WIDTH-1:0]             rdata;

  // s is the only validity qualifier for the bus; an undriven bus is captured as zero.
  always_comb begin
    din           = '0;
    din[IDX_AND]  = y1;
    din[IDX_OR]   = y2;
    din[IDX_XOR]  = y3;
    din[IDX_NOR]  = y4;
    din[IDX_NAND] = y5;
    din[IDX_MUX]  = y6;
    din[IDX_BUS]  = s ? y7 : '0;
  end

  gates_snap_reg #(.WIDTH(WIDTH)) u_snap (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .din   (din),
    .ridx  (idx),
    .dout  (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      zflag <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      zflag <= zflag_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    zflag_n = zflag;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SEND;
          idx_n   = '0;
          zflag_n = ~s;
          load    = 1'b1;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx == IDX_BUS) begin
            state_n = DONE;
            idx_n   = '0;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Everything below depends only on state and registers, so it holds while stalled.
  assign out_valid = (state == SEND);
  assign out_data  = out_valid ? rdata : '0;
  assign out_idx   = idx;
  assign out_last  = out_valid && (idx == IDX_BUS);
  assign out_zflag = out_last && zflag;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule
